// File: rtl/gpio_out_mmio.sv
// rtl/gpio_out_mmio.sv - memory-mapped GPIO output block with set/clear/toggle and a timed one-shot pulse.
// Optional pulse engine (PULSE_LEN, PULSE, counter, FSM) is built only when GPIO_PULSE_EN is defined.
module gpio_out_mmio #(
   parameter int          WIDTH     = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0040,
   parameter int          PULSE_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [31:0]      addr_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o,
   output logic             hit_o,
   output logic [WIDTH-1:0] GPIO_o,
   output logic             busy_o
);

   localparam logic [2:0] OFF_DATA  = 3'd0;
   localparam logic [2:0] OFF_SET   = 3'd1;
   localparam logic [2:0] OFF_CLR   = 3'd2;
   localparam logic [2:0] OFF_TOG   = 3'd3;
   localparam logic [2:0] OFF_LEN   = 3'd4;
   localparam logic [2:0] OFF_PULSE = 3'd5;

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] bus_d;
   logic [WIDTH-1:0] wmask;
   logic [2:0]       offset;
   logic             wr;

   assign hit_o  = (addr_i[31:5] == BASE_ADDR[31:5]);
   assign offset = addr_i[4:2];
   assign wmask  = wdata_i[WIDTH-1:0];
   assign wr     = we_i & hit_o;
   assign GPIO_o = data_q;

   // Result of the bus write alone; the pulse engine layers on top of this.
   always_comb begin
      bus_d = data_q;
      if (wr) begin
         case (offset)
            OFF_DATA: bus_d = wmask;
            OFF_SET:  bus_d = data_q | wmask;
            OFF_CLR:  bus_d = data_q & ~wmask;
            OFF_TOG:  bus_d = data_q ^ wmask;
            default:  bus_d = data_q;
         endcase
      end
   end

   logic unused_bits;
   assign unused_bits = ^{addr_i[1:0], wdata_i};

`ifdef GPIO_PULSE_EN
   typedef enum logic {IDLE, PULSING} state_t;

   localparam logic [PULSE_W-1:0] ONE = PULSE_W'(1);

   state_t             state_q;
   logic [PULSE_W-1:0] plen_q;
   logic [PULSE_W-1:0] cnt_q;
   logic [WIDTH-1:0]   pmask_q;
   logic               busy_q;
   logic               pulse_wr;

   assign pulse_wr = wr && (offset == OFF_PULSE);
   assign busy_o   = busy_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         plen_q  <= ONE;
         cnt_q   <= '0;
         pmask_q <= '0;
         state_q <= IDLE;
         busy_q  <= 1'b0;
      end else begin
         data_q <= bus_d;
         if (wr && (offset == OFF_LEN))
            plen_q <= wdata_i[PULSE_W-1:0];
         case (state_q)
            IDLE: begin
               if (pulse_wr && (wmask != '0)) begin
                  data_q  <= bus_d | wmask;
                  pmask_q <= wmask;
                  cnt_q   <= (plen_q == '0) ? '0 : plen_q - ONE;
                  state_q <= PULSING;
                  busy_q  <= 1'b1;
               end
            end
            PULSING: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - ONE;
               end else begin
                  // Pulse end wins over a same-edge bus write on pulsed bits only.
                  data_q  <= bus_d & ~pmask_q;
                  pmask_q <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
`else
   assign busy_o = 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         data_q <= '0;
      else
         data_q <= bus_d;
   end
`endif

   always_comb begin
      rdata_o = '0;
      if (hit_o) begin
         case (offset)
            OFF_DATA: rdata_o = 32'(data_q);
`ifdef GPIO_PULSE_EN
            OFF_LEN:  rdata_o = 32'(plen_q);
            OFF_PULSE: begin
               rdata_o     = 32'(pmask_q);
               rdata_o[31] = busy_q;
            end
`endif
            default:  rdata_o = '0;
         endcase
      end
   end

endmodule
